byte_window_fifo: RTL and testbench

//  Parametrised byte-granular ring buffer between a wide word source (BRAM read port) and a

---
 rtl/byte_window_pkg.sv | 21 ++
 rtl/byte_ring_window_mux.sv | 26 ++
 rtl/byte_window_fifo.sv | 92 +++++++++
 tb/tb_byte_window_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/byte_window_pkg.sv
// Shared constants and width helpers for the byte-granular window FIFO.
// Width constants below describe the default 8-in / 16-deep configuration.
package byte_window_pkg;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_IN_BYTES    = 8;
  localparam int DEF_DEPTH_BYTES = 16;

  localparam int PTR_W = clog2(DEF_DEPTH_BYTES);
  localparam int OCC_W = clog2(DEF_DEPTH_BYTES + 1);
  localparam int NB_W  = clog2(DEF_IN_BYTES + 1);

endpackage

// File: rtl/byte_ring_window_mux.sv
// Selects WIN_BYTES consecutive bytes from a ring starting at a read pointer.
// The index wraps naturally because the ring depth is a power of two.
module byte_ring_window_mux
  import byte_window_pkg::*;
#(
  parameter int DEPTH_BYTES = 16,
  parameter int WIN_BYTES   = 3,
  parameter int RD_W        = 4
) (
  input  logic [BYTE_W-1:0]           i_mem [DEPTH_BYTES],
  input  logic [RD_W-1:0]             i_rd_ptr,
  output logic [WIN_BYTES*BYTE_W-1:0] o_win_data
);

  logic [RD_W-1:0] w_idx;

  always_comb begin
    o_win_data = '0;
    w_idx      = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      w_idx = i_rd_ptr + RD_W'(i);
      o_win_data[i*BYTE_W +: BYTE_W] = i_mem[w_idx];
    end
  end

endmodule

// File: rtl/byte_window_fifo.sv
// Byte ring buffer packing wide words and presenting a sliding window.
// Occupancy is held in its own register rather than derived from pointers.
module byte_window_fifo
  import byte_window_pkg::*;
#(
  parameter int IN_BYTES    = 8,
  parameter int WIN_BYTES   = 3,
  parameter int STRIDE      = 1,
  parameter int DEPTH_BYTES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [IN_BYTES*BYTE_W-1:0]        in_data,
  input  logic [clog2(IN_BYTES+1)-1:0]      in_nbytes,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WIN_BYTES*BYTE_W-1:0]       win_data,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic [clog2(DEPTH_BYTES+1)-1:0]   occupancy
);

  localparam int PW = clog2(DEPTH_BYTES);
  localparam int OW = clog2(DEPTH_BYTES + 1);
  localparam int NW = clog2(IN_BYTES + 1);

  if (STRIDE < 1 || STRIDE > WIN_BYTES) begin : g_bad_stride
    $error("byte_window_fifo: STRIDE must be in 1..WIN_BYTES");
  end
  if ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0 ||
      DEPTH_BYTES < IN_BYTES + WIN_BYTES) begin : g_bad_depth
    $error("byte_window_fifo: bad DEPTH_BYTES");
  end

  logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [OW-1:0]     r_occ;

  logic [NW-1:0]     w_n;
  logic              w_push;
  logic              w_pop;
  logic [OW-1:0]     w_add;
  logic [OW-1:0]     w_sub;

  // Oversized byte counts are clamped to a full word.
  assign w_n = (in_nbytes > NW'(IN_BYTES)) ? NW'(IN_BYTES) : in_nbytes;

  assign in_ready  = r_occ <= OW'(DEPTH_BYTES - IN_BYTES);
  assign win_valid = r_occ >= OW'(WIN_BYTES);
  assign occupancy = r_occ;

  assign w_push = in_valid & in_ready;
  assign w_pop  = win_valid & win_ready;
  assign w_add  = w_push ? OW'(w_n) : '0;
  assign w_sub  = w_pop ? OW'(STRIDE) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        for (int k = 0; k < IN_BYTES; k++) begin
          if (NW'(k) < w_n)
            r_mem[r_wr_ptr + PW'(k)] <= in_data[k*BYTE_W +: BYTE_W];
        end
        r_wr_ptr <= r_wr_ptr + PW'(w_n);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(STRIDE);
      r_occ <= r_occ + w_add - w_sub;
    end
  end

  byte_ring_window_mux #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WIN_BYTES   (WIN_BYTES),
    .RD_W        (PW)
  ) u_mux (
    .i_mem      (r_mem),
    .i_rd_ptr   (r_rd_ptr),
    .o_win_data (win_data)
  );

endmodule

// File: tb/tb_byte_window_fifo.sv
// Directed and random checks of byte_window_fifo against a byte-queue model.
// The model treats the buffer as an ordered byte stream with a size limit.
module tb_byte_window_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_nbytes = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] win_data;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [4:0]  occupancy;

  int checks = 0;
  int errors = 0;
  bit known = 0;
  byte unsigned q[$];

  always #5 clk = ~clk;

  byte_window_fifo #(
    .IN_BYTES    (8),
    .WIN_BYTES   (3),
    .STRIDE      (1),
    .DEPTH_BYTES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [63:0] d, input int nb, input bit wr);
    bit exp_rdy;
    bit exp_v;
    int n;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_nbytes = 4'(nb);
    win_ready = wr;
    @(negedge clk);
    exp_rdy = (16 - q.size()) >= 8;
    exp_v   = q.size() >= 3;
    if (known) begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("win_valid", 64'(win_valid), 64'(exp_v));
      if (exp_v) chk("win_data", 64'(win_data), 64'({q[2], q[1], q[0]}));
    end
    if (rst || fl) begin
      q.delete();
      if (rst) known = 1;
    end else begin
      if (wr && exp_v) void'(q.pop_front());
      if (iv && exp_rdy) begin
        n = (nb > 8) ? 8 : nb;
        for (int k = 0; k < n; k++) q.push_back(d[8*k +: 8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // reset state
    step(1, 0, 0, '0, 0, 0);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_win_valid", 64'(win_valid), 0);
    chk("rst_win_data", 64'(win_data), 0);

    // basic push then six single-byte pops
    step(0, 0, 1, 64'h0706050403020100, 8, 0);
    chk("t1_occ", 64'(occupancy), 8);
    chk("t1_valid", 64'(win_valid), 1);
    chk("t1_win", 64'(win_data), 64'h020100);
    repeat (6) step(0, 0, 0, '0, 0, 1);
    chk("t1_occ_end", 64'(occupancy), 2);
    chk("t1_valid_end", 64'(win_valid), 0);

    // full and in_ready recovery
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, rnd64(), 8, 0);
    step(0, 0, 1, rnd64(), 8, 0);
    chk("t2_occ_full", 64'(occupancy), 16);
    chk("t2_rdy_full", 64'(in_ready), 0);
    step(0, 0, 0, '0, 0, 1);
    chk("t2_occ15", 64'(occupancy), 15);
    chk("t2_rdy15", 64'(in_ready), 0);
    repeat (6) step(0, 0, 0, '0, 0, 1);
    chk("t2_rdy9", 64'(in_ready), 0);
    step(0, 0, 0, '0, 0, 1);
    chk("t2_rdy8", 64'(in_ready), 1);

    // window straddling the wrap point
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, rnd64(), 8, 0);
    repeat (6) step(0, 0, 0, '0, 0, 1);
    step(0, 0, 1, 64'hBBAA_1111_2222_3333, 8, 0);
    repeat (8) step(0, 0, 0, '0, 0, 1);
    step(0, 0, 1, 64'h00000000000000CC, 1, 0);
    chk("t3_win_wrap", 64'(win_data), 64'hCCBBAA);

    // simultaneous push and pop
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, rnd64(), 8, 0);
    step(0, 0, 1, rnd64(), 8, 1);
    chk("t4_occ", 64'(occupancy), 15);

    // partial word
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, 64'hFFFFFFFFFF030201, 3, 0);
    chk("t5_occ", 64'(occupancy), 3);
    chk("t5_win", 64'(win_data), 64'h030201);
    step(0, 0, 1, rnd64(), 0, 0);
    chk("t5_nb0_occ", 64'(occupancy), 3);

    // flush with concurrent push/pop
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, rnd64(), 8, 0);
    step(0, 0, 1, rnd64(), 2, 0);
    chk("t6_occ10", 64'(occupancy), 10);
    step(0, 1, 1, rnd64(), 8, 1);
    chk("t6f_occ", 64'(occupancy), 0);
    chk("t6f_valid", 64'(win_valid), 0);
    chk("t6f_rdy", 64'(in_ready), 1);

    // reset with concurrent push/pop
    step(0, 0, 1, rnd64(), 8, 0);
    step(0, 0, 1, rnd64(), 2, 0);
    step(1, 0, 1, rnd64(), 8, 1);
    chk("t6r_occ", 64'(occupancy), 0);
    chk("t6r_valid", 64'(win_valid), 0);
    chk("t6r_rdy", 64'(in_ready), 1);
    chk("t6r_win", 64'(win_data), 0);

    // random traffic, including oversized byte counts and flushes
    for (int i = 0; i < 800; i++) begin
      step(0, ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           rnd64(), int'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
